// File: rtl/circulant_transpose_stream.sv
// Streaming NxN transpose: rows land in N circulant-skewed banks so each column reads conflict-free.
// Column 0 is valid 2 edges after the last row; a 2-entry output FIFO absorbs consumer stalls.
module circulant_transpose_stream #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int LN = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic [LN-1:0]  out_idx,
  output logic           out_last,
  output logic           busy
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [LN-1:0]  wr_cnt, rd_cnt;
  logic           issue_done;
  logic           rd_vld_q, rd_last_q;
  logic [LN-1:0]  rd_col_q;
  logic [N*W-1:0] rd_flat, deskew;
  logic [LN-1:0]  sel;
  logic [N*W-1:0] fifo_col [2];
  logic [LN-1:0]  fifo_idx [2];
  logic [1:0]     fifo_last;
  logic           wr_ptr, rd_ptr;
  logic [1:0]     occ;
  logic           wr_en, issue, pop, push;

  assign in_ready  = (state == FILL);
  assign wr_en     = in_valid & in_ready;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = rd_vld_q;
  // Occupancy plus the read in flight never exceeds 2, so the FIFO cannot overflow.
  assign issue     = (state == DRAIN) && !issue_done &&
                     ((({1'b0, occ} + {2'b0, rd_vld_q}) < 3'd2) || pop);
  assign out_col   = fifo_col[rd_ptr];
  assign out_idx   = fifo_idx[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];
  assign busy      = (state == DRAIN) || out_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (wr_en && wr_cnt == LN'(N-1)) state_nxt = DRAIN;
      DRAIN: if (pop && out_last) state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      issue_done <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_col_q   <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_cnt <= wr_cnt + LN'(1);
      if (wr_en && wr_cnt == LN'(N-1)) begin
        rd_cnt     <= '0;
        issue_done <= 1'b0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + LN'(1);
        if (rd_cnt == LN'(N-1)) issue_done <= 1'b1;
      end
      rd_vld_q  <= issue;
      rd_col_q  <= rd_cnt;
      rd_last_q <= (rd_cnt == LN'(N-1));
    end
  end

  // Bank b holds element (r,c) with (r+c) mod N == b at address r.
  for (genvar b = 0; b < N; b++) begin : g_bank
    logic [W-1:0]  mem [N];
    logic [W-1:0]  rd_q;
    logic [LN-1:0] wr_lane, rd_addr;
    assign wr_lane = LN'(b) - wr_cnt;
    assign rd_addr = LN'(b) - rd_cnt;
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_cnt] <= in_row[wr_lane*W +: W];
      if (issue) rd_q <= mem[rd_addr];
    end
    assign rd_flat[b*W +: W] = rd_q;
  end

  always_comb begin
    deskew = '0;
    sel    = '0;
    for (int r = 0; r < N; r++) begin
      sel = LN'(r) + rd_col_q;
      deskew[r*W +: W] = rd_flat[sel*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      fifo_last <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_col[i] <= '0;
        fifo_idx[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_col[wr_ptr]  <= deskew;
        fifo_idx[wr_ptr]  <= rd_col_q;
        fifo_last[wr_ptr] <= rd_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_circulant_transpose_stream.sv
// Scoreboard bench: transposes computed from whole matrices, compared as columns pop out.
`timescale 1ns/1ps
module tb_circulant_transpose_stream;

  typedef logic [7:0] mat_t [8][8];
  typedef struct { logic [63:0] col; int idx; bit last; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, in_valid4, in_ready4, out_valid4, out_ready4, out_last4, busy4;
  logic [31:0] in_row4, out_col4;
  logic [1:0]  out_idx4;
  logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
  logic [63:0] in_row8, out_col8;
  logic [2:0]  out_idx8;

  circulant_transpose_stream #(.N(4), .W(8)) u4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .in_row(in_row4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_col(out_col4), .out_idx(out_idx4),
    .out_last(out_last4), .busy(busy4));

  circulant_transpose_stream #(.N(8), .W(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_row(in_row8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_col(out_col8), .out_idx(out_idx8),
    .out_last(out_last8), .busy(busy8));

  int   checks = 0, errors = 0, cyc = 0, pops4 = 0, rdy_mode = 0, last_pop_cyc = -10;
  exp_t q4[$], q8[$];
  bit   stall4;
  logic [31:0] h_col4;
  logic [1:0]  h_idx4;
  logic        h_last4;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer readiness patterns: always, 1010, 1010 with 5-cycle holds, random.
  initial begin
    int k;
    k = 0;
    out_ready4 = 1'b1;
    out_ready8 = 1'b1;
    forever begin
      @(posedge clk); #1;
      k++;
      case (rdy_mode)
        0: out_ready4 = 1'b1;
        1: out_ready4 = k[0];
        2: out_ready4 = ((k % 12) >= 4 && (k % 12) < 9) ? 1'b0 : k[0];
        default: out_ready4 = 1'($urandom_range(0, 1));
      endcase
      out_ready8 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    stall4 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst4) begin
        stall4 = 1'b0;
        continue;
      end
      chk("in_ready4", in_ready4, (q4.size() == 0));
      chk("busy4", busy4, (q4.size() != 0));
      if (stall4) begin
        chk("stall_valid4", out_valid4, 1'b1);
        chk("stall_col4", out_col4, h_col4);
        chk("stall_idx4", out_idx4, h_idx4);
        chk("stall_last4", out_last4, h_last4);
      end
      stall4  = out_valid4 && !out_ready4;
      h_col4  = out_col4;
      h_idx4  = out_idx4;
      h_last4 = out_last4;
      if (out_valid4 && out_ready4) begin
        if (q4.size() == 0) chk("extra_col4", q4.size(), 1);
        else begin
          e = q4.pop_front();
          chk("col4", out_col4, e.col[31:0]);
          chk("idx4", out_idx4, e.idx);
          chk("last4", out_last4, e.last);
          if (rdy_mode == 0 && e.idx != 0) chk("consec4", cyc, last_pop_cyc + 1);
          last_pop_cyc = cyc;
          pops4++;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst8) continue;
      chk("in_ready8", in_ready8, (q8.size() == 0));
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) chk("extra_col8", q8.size(), 1);
        else begin
          e = q8.pop_front();
          chk("col8", out_col8, e.col);
          chk("idx8", out_idx8, e.idx);
          chk("last8", out_last8, e.last);
        end
      end
    end
  end

  task automatic send(input int n, input mat_t m, input bit gaps);
    int r, t;
    logic [63:0] row;
    bit v, acc;
    exp_t e;
    r = 0;
    t = 0;
    while (r < n && t < 400) begin
      row = '0;
      for (int c = 0; c < n; c++) row[c*8 +: 8] = m[r][c];
      v = !(gaps && $urandom_range(0, 2) == 0);
      if (n == 4) begin
        in_valid4 = v; in_row4 = row[31:0]; acc = v && in_ready4;
      end else begin
        in_valid8 = v; in_row8 = row; acc = v && in_ready8;
      end
      @(posedge clk); #1;
      t++;
      if (acc) begin
        r++;
        if (r == n) begin
          for (int c = 0; c < n; c++) begin
            e.col = '0;
            for (int rr = 0; rr < n; rr++) e.col[rr*8 +: 8] = m[rr][c];
            e.idx = c;
            e.last = (c == n - 1);
            if (n == 4) q4.push_back(e); else q8.push_back(e);
          end
          chk("lat_edge0", (n == 4) ? out_valid4 : out_valid8, 1'b0);
          @(posedge clk); #1;
          chk("lat_edge1", (n == 4) ? out_valid4 : out_valid8, 1'b0);
          @(posedge clk); #1;
          chk("lat_edge2", (n == 4) ? out_valid4 : out_valid8, 1'b1);
        end
      end
    end
    if (r < n) chk("fill_timeout", r, n);
  endtask

  initial begin
    mat_t a, b;
    int base, t;
    rst4 = 1'b1; rst8 = 1'b1;
    in_valid4 = 1'b0; in_valid8 = 1'b0; in_row4 = '0; in_row8 = '0;
    #1;
    chk("rst_out_valid", out_valid4, 1'b0);
    chk("rst_out_last", out_last4, 1'b0);
    chk("rst_out_idx", out_idx4, 2'd0);
    chk("rst_out_col", out_col4, 32'd0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_in_ready", in_ready4, 1'b1);
    chk("rst_out_valid8", out_valid8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0; rst8 = 1'b0;

    rdy_mode = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'(r*16 + c);
    send(4, a, 1'b0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b[r][c] = 8'hF0 ^ a[r][c];
    send(4, b, 1'b0);

    for (int mode = 1; mode < 4; mode++) begin
      rdy_mode = mode;
      for (int rep = 0; rep < 2; rep++) begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'($urandom);
        send(4, a, 1'b1);
      end
    end

    rdy_mode = 1;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'($urandom);
    send(4, a, 1'b0);
    base = pops4;
    t = 0;
    while (pops4 < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("pops_before_reset", (pops4 >= base + 2), 1'b1);
    #1;
    in_valid4 = 1'b0;
    rst4 = 1'b1;
    q4.delete();
    #1;
    chk("midrst_out_valid", out_valid4, 1'b0);
    chk("midrst_in_ready", in_ready4, 1'b1);
    chk("midrst_busy", busy4, 1'b0);
    chk("midrst_out_last", out_last4, 1'b0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    rdy_mode = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'($urandom);
    send(4, a, 1'b0);
    in_valid4 = 1'b0;

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'(r*8 + c);
    send(8, a, 1'b0);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 8'($urandom);
    send(8, a, 1'b1);
    in_valid8 = 1'b0;

    t = 0;
    while ((q4.size() != 0 || q8.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    chk("drain_q4", q4.size(), 0);
    chk("drain_q8", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
